// File: rtl/shared_memory_mp.sv
// Multi-port shared scratch memory: NUM_PORTS read/write ports on one
// DEPTH x DATA_W array, registered reads with valid pulses, fixed-priority
// write arbitration and a one-word-per-cycle clear sweep after reset or on request.
module shared_memory_mp #(
  parameter int NUM_PORTS = 2,
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 4,
  parameter int RD_MODE   = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clear_req,
  output logic                          busy,
  input  logic [NUM_PORTS*ADDR_W-1:0]   addr,
  input  logic [NUM_PORTS*DATA_W-1:0]   wdata,
  input  logic [NUM_PORTS-1:0]          we,
  input  logic [NUM_PORTS-1:0]          re,
  output logic [NUM_PORTS*DATA_W-1:0]   rdata,
  output logic [NUM_PORTS-1:0]          rvalid,
  output logic [NUM_PORTS-1:0]          wr_collision
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  state_t                      state, state_nxt;
  logic [ADDR_W-1:0]           clr_ptr, clr_ptr_nxt;
  logic [DATA_W-1:0]           mem [DEPTH];
  logic                        run;
  logic [NUM_PORTS-1:0]        win, lose;
  logic [NUM_PORTS*DATA_W-1:0] rd_word;

  assign run  = (state == ST_RUN);
  assign busy = (state == ST_CLEAR);

  // FSM state and sweep pointer register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_CLEAR;
      clr_ptr <= '0;
    end else begin
      state   <= state_nxt;
      clr_ptr <= clr_ptr_nxt;
    end
  end

  // Next state: sweep all words, then serve ports until a clear is requested
  always_comb begin
    state_nxt   = state;
    clr_ptr_nxt = clr_ptr;
    case (state)
      ST_CLEAR: begin
        clr_ptr_nxt = clr_ptr + 1'b1;
        if (clr_ptr == LAST_ADDR) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (clear_req) begin
          state_nxt   = ST_CLEAR;
          clr_ptr_nxt = '0;
        end
      end
      default: begin
        state_nxt   = ST_CLEAR;
        clr_ptr_nxt = '0;
      end
    endcase
  end

  // Write arbitration: a write loses to any lower-index port writing the same address
  always_comb begin
    win  = '0;
    lose = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      win[p] = run && we[p];
      for (int unsigned q = 0; q < p; q++) begin
        if (run && we[q] && (addr[q*ADDR_W +: ADDR_W] == addr[p*ADDR_W +: ADDR_W]))
          win[p] = 1'b0;
      end
      lose[p] = run && we[p] && !win[p];
    end
  end

  // Read word per port; write-first mode forwards the winning write of this cycle
  // (winners always target distinct addresses, so at most one can match)
  always_comb begin
    logic [ADDR_W-1:0] ra;
    ra      = '0;
    rd_word = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      ra = addr[p*ADDR_W +: ADDR_W];
      rd_word[p*DATA_W +: DATA_W] = mem[ra];
      if (RD_MODE == 1) begin
        for (int unsigned q = 0; q < NUM_PORTS; q++) begin
          if (win[q] && (addr[q*ADDR_W +: ADDR_W] == ra))
            rd_word[p*DATA_W +: DATA_W] = wdata[q*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Storage array: sweep clears one word per cycle, otherwise commit winning writes
  always_ff @(posedge clk) begin
    if (state == ST_CLEAR) begin
      mem[clr_ptr] <= '0;
    end else begin
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        if (win[p]) mem[addr[p*ADDR_W +: ADDR_W]] <= wdata[p*DATA_W +: DATA_W];
      end
    end
  end

  // Registered read data, valid and collision pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata        <= '0;
      rvalid       <= '0;
      wr_collision <= '0;
    end else begin
      rvalid       <= run ? re : '0;
      wr_collision <= lose;
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        if (run && re[p]) rdata[p*DATA_W +: DATA_W] <= rd_word[p*DATA_W +: DATA_W];
      end
    end
  end

endmodule
